// File: rtl/calc_sched_pkg.sv
// calc_sched shared types: scheduler states, default widths, engine handshake.
// Optional CALC_SCHED_TIMEOUT_EN adds an engine watchdog in calc_sched.
package calc_sched_pkg;

  localparam int N_W_DEF   = 6;
  localparam int VAL_W_DEF = 13;

  typedef enum logic [2:0] {
    e_idle,
    e_launch,
    e_wait,
    e_clear,
    e_resp
  } t_sched_state;

  // Engine side of the start/clear/done handshake
  typedef struct packed {
    logic                 start;
    logic                 clear;
    logic [N_W_DEF-1:0]   n;
  } t_eng_req;

  typedef struct packed {
    logic                 done;
    logic [VAL_W_DEF-1:0] val;
  } t_eng_rsp;

  function automatic int unsigned rr_next(
    input int unsigned id,
    input int unsigned num
  );
    return (id + 1 >= num) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/calc_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping; returns one-hot winner and its index.
module rr_arbiter
  import calc_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  int   k;
  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/calc_sched.sv
// Round-robin scheduler sharing one calc engine among NUM_REQ requesters.
// Define CALC_SCHED_TIMEOUT_EN to abort stalled engine runs after TIMEOUT_CYC.
module calc_sched
  import calc_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int N_W         = N_W_DEF,
  parameter int VAL_W       = VAL_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_REQ-1:0]     i_req,
  input  logic [NUM_REQ*N_W-1:0] i_req_n,
  input  logic [NUM_REQ-1:0]     i_rsp_ack,
  output logic [NUM_REQ-1:0]     o_grant,
  output logic [NUM_REQ-1:0]     o_rsp_valid,
  output logic [VAL_W-1:0]       o_rsp_val,
  output logic                   o_rsp_err,
  output logic                   o_busy,
  output logic                   o_eng_start,
  output logic [N_W-1:0]         o_eng_n,
  output logic                   o_eng_clear,
  input  logic                   i_eng_done,
  input  logic [VAL_W-1:0]       i_eng_val
);

  localparam int ID_W = $clog2(NUM_REQ);

  t_sched_state state_q, state_d;

  logic [ID_W-1:0]    ptr_q;
  logic [ID_W-1:0]    id_q;
  logic [ID_W-1:0]    win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] own_oh;
  logic [N_W-1:0]     n_q;
  logic [VAL_W-1:0]   val_q;
  logic               err_q;
  logic               any_req;
  logic               owner_ack;
  logic               expire;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_arb (
    .req (i_req),
    .ptr (ptr_q),
    .gnt (win_oh),
    .idx (win_idx)
  );

  assign any_req   = |win_oh;
  assign own_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << id_q;
  assign owner_ack = i_rsp_ack[id_q];

`ifdef CALC_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (state_q == e_launch) begin
      cnt_q <= CNT_W'(TIMEOUT_CYC);
    end else if (state_q == e_wait && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire = (cnt_q == '0);
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= e_idle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      e_idle: begin
        if (any_req) state_d = e_launch;
      end
      e_launch: begin
        state_d = e_wait;
      end
      e_wait: begin
        if (i_eng_done || expire) state_d = e_clear;
      end
      e_clear: begin
        state_d = e_resp;
      end
      e_resp: begin
        if (owner_ack) state_d = e_idle;
      end
      default: begin
        state_d = e_idle;
      end
    endcase
  end

  // Done has priority over a watchdog expiry in the same cycle
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q <= '0;
      id_q  <= '0;
      n_q   <= '0;
      val_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (state_q == e_idle && any_req) begin
        id_q <= win_idx;
        n_q  <= i_req_n[win_idx*N_W +: N_W];
      end
      if (state_q == e_wait) begin
        if (i_eng_done) begin
          val_q <= i_eng_val;
          err_q <= 1'b0;
        end else if (expire) begin
          val_q <= '0;
          err_q <= 1'b1;
        end
      end
      if (state_q == e_resp && owner_ack) begin
        ptr_q <= ID_W'(rr_next(int'(id_q), NUM_REQ));
      end
    end
  end

  always_comb begin
    o_grant     = '0;
    o_rsp_valid = '0;
    o_rsp_val   = '0;
    o_rsp_err   = 1'b0;
    o_busy      = (state_q != e_idle);
    o_eng_start = (state_q == e_launch);
    o_eng_clear = (state_q == e_clear);
    o_eng_n     = n_q;
    if (state_q != e_idle) begin
      o_grant = own_oh;
    end
    if (state_q == e_resp) begin
      o_rsp_valid = own_oh;
      o_rsp_val   = val_q;
      o_rsp_err   = err_q;
    end
  end

endmodule
